// File: rtl/lin_pkg.sv
// Shared definitions for the LIN master frame sequencer: state encoding,
// fixed byte values, error codes and the PID / checksum arithmetic.
package lin_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BREAK,
        ST_DELIM,
        ST_REQ,
        ST_GUARD,
        ST_WAIT_ACK,
        ST_ABORT
    } lin_state_e;

    localparam logic [7:0] SYNC_BYTE    = 8'h55;
    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_READBACK = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

    function automatic logic [7:0] lin_pid(input logic [5:0] id);
        logic p0;
        logic p1;
        p0 = id[0] ^ id[1] ^ id[2] ^ id[4];
        p1 = ~(id[1] ^ id[3] ^ id[4] ^ id[5]);
        return {p1, p0, id};
    endfunction

    // End-around carry: a sum above 255 wraps to sum - 255.
    function automatic logic [7:0] lin_csum_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[7:0] + {7'd0, s[8]};
    endfunction

endpackage

// File: rtl/lin_csum_acc.sv
// LIN checksum accumulator: clear, add one byte per cycle, inverted result.
module lin_csum_acc
    import lin_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       add,
    input  logic [7:0] add_data,
    output logic [7:0] csum
);

    logic [7:0] acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= 8'd0;
        end else if (clr) begin
            acc <= 8'd0;
        end else if (add) begin
            acc <= lin_csum_add(acc, add_data);
        end
    end

    assign csum = ~acc;

endmodule

// File: rtl/lin_frame_tx_ctrl.sv
// LIN master frame sequencer: break/delimiter via serializer bypass, then
// sync, PID, data and checksum over the byte req/ack handshake.
module lin_frame_tx_ctrl
    import lin_pkg::*;
#(
    parameter int MAX_DATA    = 8,
    parameter int BREAK_BITS  = 13,
    parameter int DELIM_BITS  = 1,
    parameter int ACK_TIMEOUT = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bit_tick,
    input  logic                  start,
    input  logic [5:0]            frame_id,
    input  logic [3:0]            data_len,
    input  logic                  enhanced,
    input  logic [8*MAX_DATA-1:0] frame_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic                  bypass,
    output logic                  bypass_data,
    output logic                  byte_req,
    output logic [7:0]            byte_data,
    input  logic                  byte_ack,
    input  logic                  byte_err
);

    localparam logic [3:0] MAX_LEN  = 4'(MAX_DATA);
    localparam logic [7:0] BREAK_LD = 8'(BREAK_BITS);
    localparam logic [7:0] DELIM_LD = 8'(DELIM_BITS);
    localparam logic [7:0] ACK_LD   = 8'(ACK_TIMEOUT);

    lin_state_e  state, state_nx;
    logic [7:0]  cnt, cnt_nx;
    logic [3:0]  idx, idx_nx;
    logic [3:0]  len_q, last_idx;
    logic [2:0]  data_k;
    logic [7:0]  pid_q, csum, byte_sel;
    logic        enh_q, start_ok, acc_add;
    logic [63:0] data_q;
    logic        busy_nx, done_nx, err_nx, bypass_nx, bypass_data_nx, byte_req_nx;
    logic [1:0]  err_code_nx;
    logic [7:0]  byte_data_nx;

    assign start_ok = (state == ST_IDLE) && start;
    // Header-only frames (len 0) carry no checksum byte.
    assign last_idx = (len_q == 4'd0) ? 4'd1 : len_q + 4'd2;
    assign data_k   = 3'(idx_nx - 4'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q  <= 4'd0;
            pid_q  <= 8'd0;
            enh_q  <= 1'b0;
            data_q <= 64'd0;
        end else if (start_ok) begin
            len_q  <= (data_len > MAX_LEN) ? MAX_LEN : data_len;
            pid_q  <= lin_pid(frame_id);
            enh_q  <= enhanced && (frame_id != 6'h3C) && (frame_id != 6'h3D);
            data_q <= 64'(frame_data);
        end
    end

    always_comb begin
        byte_sel = csum;
        if (idx_nx == 4'd0) begin
            byte_sel = SYNC_BYTE;
        end else if (idx_nx == 4'd1) begin
            byte_sel = pid_q;
        end else if (idx_nx <= len_q + 4'd1) begin
            byte_sel = data_q[{data_k, 3'b000} +: 8];
        end
        acc_add = (state_nx == ST_REQ) &&
                  (((idx_nx == 4'd1) && enh_q) ||
                   ((idx_nx >= 4'd2) && (idx_nx <= len_q + 4'd1)));
    end

    lin_csum_acc u_csum (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_ok),
        .add      (acc_add),
        .add_data (byte_sel),
        .csum     (csum)
    );

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        idx_nx      = idx;
        err_code_nx = err_code;
        done_nx     = 1'b0;
        err_nx      = 1'b0;
        case (state)
            ST_IDLE: if (start) begin
                state_nx    = ST_BREAK;
                cnt_nx      = BREAK_LD;
                err_code_nx = ERR_NONE;
            end
            ST_BREAK: if (bit_tick) begin
                if (cnt <= 8'd1) begin
                    state_nx = ST_DELIM;
                    cnt_nx   = DELIM_LD;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            ST_DELIM: if (bit_tick) begin
                if (cnt <= 8'd1) begin
                    state_nx = ST_REQ;
                    idx_nx   = 4'd0;
                    cnt_nx   = ACK_LD;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            // The ack timer starts with the request; ticks in REQ/GUARD count.
            ST_REQ, ST_GUARD: begin
                state_nx = (state == ST_REQ) ? ST_GUARD : ST_WAIT_ACK;
                if (bit_tick && (cnt > 8'd1)) cnt_nx = cnt - 8'd1;
            end
            ST_WAIT_ACK: begin
                if (byte_err) begin
                    state_nx    = ST_ABORT;
                    err_code_nx = ERR_READBACK;
                end else if (byte_ack) begin
                    if (idx == last_idx) begin
                        state_nx = ST_IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = ST_REQ;
                        idx_nx   = idx + 4'd1;
                        cnt_nx   = ACK_LD;
                    end
                end else if ((cnt == 8'd0) || (bit_tick && (cnt == 8'd1))) begin
                    state_nx    = ST_ABORT;
                    err_code_nx = ERR_TIMEOUT;
                end else if (bit_tick) begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            ST_ABORT: if (bit_tick) begin
                state_nx = ST_IDLE;
                err_nx   = 1'b1;
            end
            default: state_nx = ST_IDLE;
        endcase

        busy_nx        = (state_nx != ST_IDLE);
        bypass_nx      = (state_nx == ST_BREAK) || (state_nx == ST_DELIM) || (state_nx == ST_ABORT);
        bypass_data_nx = (state_nx != ST_BREAK);
        byte_req_nx    = (state_nx == ST_REQ);
        byte_data_nx   = (state_nx == ST_REQ) ? byte_sel : byte_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= 8'd0;
            idx         <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
            bypass      <= 1'b0;
            bypass_data <= 1'b1;
            byte_req    <= 1'b0;
            byte_data   <= 8'd0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            idx         <= idx_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            err         <= err_nx;
            err_code    <= err_code_nx;
            bypass      <= bypass_nx;
            bypass_data <= bypass_data_nx;
            byte_req    <= byte_req_nx;
            byte_data   <= byte_data_nx;
        end
    end

endmodule
